// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side request/grant/valid bundle for the port arbiter.
// The arbiter takes the master view; the environment around it takes slave.
interface mem_port_arbiter_if;
  logic        instr_req;
  logic [31:0] instr_adr;
  logic        instr_gnt;
  logic        instr_r_valid;
  logic [31:0] instr_read;

  logic        data_req;
  logic [31:0] data_adr;
  logic        data_write_enable;
  logic [31:0] data_write;
  logic        data_gnt;
  logic        data_r_valid;
  logic [31:0] data_read;

  logic        mem_req;
  logic [31:0] mem_adr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_r_valid;
  logic [31:0] mem_read;

  modport master (
    input  instr_req, instr_adr,
    output instr_gnt, instr_r_valid, instr_read,
    input  data_req, data_adr, data_write_enable, data_write,
    output data_gnt, data_r_valid, data_read,
    output mem_req, mem_adr, mem_we, mem_wdata,
    input  mem_gnt, mem_r_valid, mem_read
  );

  modport slave (
    output instr_req, instr_adr,
    input  instr_gnt, instr_r_valid, instr_read,
    output data_req, data_adr, data_write_enable, data_write,
    input  data_gnt, data_r_valid, data_read,
    input  mem_req, mem_adr, mem_we, mem_wdata,
    output mem_gnt, mem_r_valid, mem_read
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data requesters.
// An in-order ID FIFO steers each response back to its issuer.
module mem_port_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned STARVE_LIMIT    = 4
) (
  input  logic               clk,
  input  logic               res,
  mem_port_arbiter_if.master bus,
  output logic [2:0]         outstanding,
  output logic               resp_err
);

  typedef enum logic {ARB, HOLD} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        owner;
  logic        winner;
  logic        sel;
  logic        mreq;
  logic        gnt;
  logic        full;
  logic        pop;
  logic        head;
  logic [3:0]  starve_cnt;
  logic [3:0]  fifo;
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;

  assign full = (count == 3'(MAX_OUTSTANDING));

  always_comb begin
    winner = bus.data_req;
    if (bus.instr_req && bus.data_req &&
        starve_cnt == 4'(STARVE_LIMIT))
      winner = 1'b0;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= ARB;
      owner <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ARB && state_nxt == HOLD)
        owner <= winner;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB:  if (mreq && !bus.mem_gnt) state_nxt = HOLD;
      HOLD: if (bus.mem_gnt) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // An un-granted request is never switched, even if a new one shows up.
  always_comb begin
    mreq = 1'b0;
    sel  = winner;
    unique case (state)
      ARB:  mreq = (bus.instr_req | bus.data_req) & ~full;
      HOLD: begin
        mreq = 1'b1;
        sel  = owner;
      end
      default: mreq = 1'b0;
    endcase
    mreq = mreq & res;
  end

  assign gnt  = mreq & bus.mem_gnt;
  assign head = fifo[rd_ptr];
  assign pop  = bus.mem_r_valid & (count != 3'd0) & res;

  assign bus.mem_req       = mreq;
  assign bus.mem_adr       = sel ? bus.data_adr : bus.instr_adr;
  assign bus.mem_we        = sel & bus.data_write_enable;
  assign bus.mem_wdata     = sel ? bus.data_write : 32'd0;
  assign bus.instr_gnt     = gnt & ~sel;
  assign bus.data_gnt      = gnt & sel;
  assign bus.instr_r_valid = pop & ~head;
  assign bus.data_r_valid  = pop & head;
  assign bus.instr_read    = bus.mem_read;
  assign bus.data_read     = bus.mem_read;
  assign outstanding       = count;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      fifo     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      resp_err <= 1'b0;
    end else begin
      if (gnt) begin
        fifo[wr_ptr] <= sel;
        wr_ptr       <= wr_ptr + 2'd1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 2'd1;
      if (gnt && !pop)
        count <= count + 3'd1;
      else if (pop && !gnt)
        count <= count - 3'd1;
      if (bus.mem_r_valid && count == 3'd0)
        resp_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res)
      starve_cnt <= '0;
    else if (!bus.instr_req || bus.instr_gnt)
      starve_cnt <= '0;
    else if (bus.data_gnt && starve_cnt != 4'(STARVE_LIMIT))
      starve_cnt <= starve_cnt + 4'd1;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, corner sequences
// and a randomized run against a queue-based reference model.
module tb_mem_port_arbiter;
  localparam int MAXO = 2;
  localparam int LIM  = 4;
  localparam logic [31:0] IA = 32'h1C00_8000;
  localparam logic [31:0] DA = 32'h0000_1000;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic [2:0] outstanding;
  logic       resp_err;
  int errors = 0;
  int checks = 0;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(
    .MAX_OUTSTANDING(MAXO),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk),
    .res(res),
    .bus(bus),
    .outstanding(outstanding),
    .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic [31:0] da;
    logic        dwe;
    logic [31:0] dwd;
    logic        mg;
    logic        mrv;
    logic [31:0] mrd;
    logic        e_req;
    logic [31:0] e_adr;
    logic        e_we;
    logic [31:0] e_wd;
    logic        e_ig;
    logic        e_dg;
    logic        e_irv;
    logic        e_drv;
    logic [2:0]  e_out;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(string t, logic mreq, logic [31:0] madr,
                         logic mwe, logic [31:0] mwd, logic ig,
                         logic dg, logic irv, logic drv,
                         logic [2:0] out, logic err);
    chk({t, ".mem_req"}, 32'(bus.mem_req), 32'(mreq));
    if (mreq) begin
      chk({t, ".mem_adr"}, bus.mem_adr, madr);
      chk({t, ".mem_we"}, 32'(bus.mem_we), 32'(mwe));
      chk({t, ".mem_wdata"}, bus.mem_wdata, mwd);
    end
    chk({t, ".instr_gnt"}, 32'(bus.instr_gnt), 32'(ig));
    chk({t, ".data_gnt"}, 32'(bus.data_gnt), 32'(dg));
    chk({t, ".instr_r_valid"}, 32'(bus.instr_r_valid), 32'(irv));
    chk({t, ".data_r_valid"}, 32'(bus.data_r_valid), 32'(drv));
    chk({t, ".outstanding"}, 32'(outstanding), 32'(out));
    chk({t, ".resp_err"}, 32'(resp_err), 32'(err));
  endtask

  task automatic drive(logic ir, logic [31:0] ia, logic dr,
                       logic [31:0] da, logic dwe, logic [31:0] dwd,
                       logic mg, logic mrv, logic [31:0] mrd);
    bus.instr_req         = ir;
    bus.instr_adr         = ia;
    bus.data_req          = dr;
    bus.data_adr          = da;
    bus.data_write_enable = dwe;
    bus.data_write        = dwd;
    bus.mem_gnt           = mg;
    bus.mem_r_valid       = mrv;
    bus.mem_read          = mrd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    res = 1'b0;
    idle();
    @(negedge clk);
    @(negedge clk);
    res = 1'b1;
  endtask

  // Reference model state: pending un-granted requester, ID queue.
  int q[$];
  int stv;
  int pend;
  bit merr;

  task automatic run_random(int n);
    logic ir, dr, dwe, mg, mrv;
    logic [31:0] ia, da, dwd, mrd;
    logic e_req, e_sel, e_gnt, hv;
    ir = 0; dr = 0; ia = 0; da = 0; dwe = 0; dwd = 0;
    q.delete();
    stv = 0;
    pend = -1;
    merr = 0;
    for (int c = 0; c < n; c++) begin
      mg  = ($urandom % 4) != 0;
      mrv = (q.size() > 0) && (($urandom % 3) != 0);
      mrd = $urandom;
      drive(ir, ia, dr, da, dwe, dwd, mg, mrv, mrd);
      e_req = 0;
      e_sel = 0;
      if (pend >= 0) begin
        e_req = 1;
        e_sel = pend[0];
      end else if (q.size() < MAXO && (ir || dr)) begin
        e_req = 1;
        if (ir && dr) e_sel = (stv == LIM) ? 1'b0 : 1'b1;
        else          e_sel = dr;
      end
      e_gnt = e_req & mg;
      hv = mrv && q.size() > 0;
      #1;
      chk_out("rnd", e_req, e_sel ? da : ia, e_sel & dwe,
              e_sel ? dwd : 32'd0, e_gnt & ~e_sel, e_gnt & e_sel,
              hv && q[0] == 0, hv && q[0] == 1, 3'(q.size()), merr);
      if (mrv) begin
        if (q.size() > 0) void'(q.pop_front());
        else merr = 1;
      end
      if (e_gnt) q.push_back(int'(e_sel));
      pend = (e_req && !mg) ? int'(e_sel) : -1;
      if (!ir || (e_gnt && !e_sel)) stv = 0;
      else if (e_gnt && e_sel && stv < LIM) stv++;
      if (ir && !(e_gnt && !e_sel)) begin
      end else begin
        ir = ($urandom % 3) != 0;
        ia = $urandom;
      end
      if (dr && !(e_gnt && e_sel)) begin
      end else begin
        dr  = ($urandom % 3) != 0;
        da  = $urandom;
        dwe = $urandom % 2;
        dwd = $urandom;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    vec_t v;
    idle();
    @(negedge clk);
    drive(1, IA, 1, DA, 1, 32'hFFFF_FFFF, 1, 1, 32'h1);
    #1;
    chk_out("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();

    // ir ia dr da dwe dwd mg mrv mrd | req adr we wd ig dg irv drv out err
    tbl.push_back(vec_t'{1, IA, 0, 0, 0, 0, 1, 0, 0,
                         1, IA, 0, 0, 1, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 1, 32'h13,
                         0, 0, 0, 0, 0, 0, 1, 0, 1, 0});
    tbl.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 0, 0,
                         0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{1, IA + 4, 0, 0, 0, 0, 1, 0, 0,
                         1, IA + 4, 0, 0, 1, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, 0, 1, DA, 1, 32'h55AA55AA, 1, 0, 0,
                         1, DA, 1, 32'h55AA55AA, 0, 1, 0, 0, 1, 0});
    tbl.push_back(vec_t'{1, IA + 8, 0, 0, 0, 0, 1, 0, 0,
                         0, 0, 0, 0, 0, 0, 0, 0, 2, 0});
    tbl.push_back(vec_t'{1, IA + 8, 0, 0, 0, 0, 1, 1, 32'h11111111,
                         0, 0, 0, 0, 0, 0, 1, 0, 2, 0});
    tbl.push_back(vec_t'{1, IA + 8, 0, 0, 0, 0, 1, 1, 32'h22222222,
                         1, IA + 8, 0, 0, 1, 0, 0, 1, 1, 0});
    tbl.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 1, 32'h33333333,
                         0, 0, 0, 0, 0, 0, 1, 0, 1, 0});
    tbl.push_back(vec_t'{1, IA + 12, 0, 0, 0, 0, 1, 0, 0,
                         1, IA + 12, 0, 0, 1, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, 0, 1, DA + 4, 0, 32'h77, 1, 1, 32'h44,
                         1, DA + 4, 0, 32'h77, 0, 1, 1, 0, 1, 0});
    tbl.push_back(vec_t'{1, IA + 16, 0, 0, 0, 0, 1, 1, 32'h55,
                         1, IA + 16, 0, 0, 1, 0, 0, 1, 1, 0});
    tbl.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 1, 32'h66,
                         0, 0, 0, 0, 0, 0, 1, 0, 1, 0});
    tbl.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 0, 0,
                         0, 0, 0, 0, 0, 0, 0, 0, 0, 0});

    foreach (tbl[i]) begin
      v = tbl[i];
      drive(v.ir, v.ia, v.dr, v.da, v.dwe, v.dwd, v.mg, v.mrv, v.mrd);
      #1;
      chk_out($sformatf("vec%0d", i), v.e_req, v.e_adr, v.e_we,
              v.e_wd, v.e_ig, v.e_dg, v.e_irv, v.e_drv,
              v.e_out, v.e_err);
      chk($sformatf("vec%0d.instr_read", i), bus.instr_read, v.mrd);
      chk($sformatf("vec%0d.data_read", i), bus.data_read, v.mrd);
      @(negedge clk);
    end

    // Contention: four data wins, then instr is forced through.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, IA, 1, DA, 0, 0, 1, i > 0, 32'hD0 + i);
      #1;
      chk_out($sformatf("cont%0d", i), 1, (i < 4) ? DA : IA, 0, 0,
              i == 4, i < 4, 0, i > 0, (i > 0) ? 3'd1 : 3'd0, 0);
      @(negedge clk);
    end
    drive(1, IA + 4, 1, DA + 4, 0, 0, 1, 1, 32'hE0);
    #1;
    chk_out("cont5", 1, DA + 4, 0, 0, 0, 1, 1, 0, 1, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'hE1);
    #1;
    chk_out("cont6", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    @(negedge clk);

    // Grant stall: a late instr request must not steal the port.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(i > 0, IA, 1, DA, 1, 32'hCAFE, i == 3, 0, 0);
      #1;
      chk_out($sformatf("stall%0d", i), 1, DA, 1, 32'hCAFE,
              0, i == 3, 0, 0, 0, 0);
      @(negedge clk);
    end
    drive(1, IA, 0, 0, 0, 0, 1, 1, 32'h9);
    #1;
    chk_out("stall4", 1, IA, 0, 0, 1, 0, 0, 1, 1, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'hA);
    #1;
    chk_out("stall5", 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    @(negedge clk);

    // Stray response, then reset mid-transaction.
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'hBAD);
    #1;
    chk_out("err0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, IA, 0, 0, 0, 0, 1, 0, 0);
    #1;
    chk_out("err1", 1, IA, 0, 0, 1, 0, 0, 0, 0, 1);
    @(negedge clk);
    idle();
    #1;
    chk_out("err2", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    drive(1, IA, 1, DA, 0, 0, 1, 1, 0);
    res = 1'b0;
    #1;
    chk_out("rstmid", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    @(negedge clk);
    res = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'hB);
    #1;
    chk_out("late0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    idle();
    #1;
    chk_out("late1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);

    do_reset();
    run_random(3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one memory port between the core's instruction-fetch and data-access request/grant/valid interfaces, so a single-ported memory can serve both. Arbitrates requests each cycle, tracks up to MAX_OUTSTANDING granted transactions in an in-order ID FIFO, and routes each response back to the requester that issued it. Sits between the processor's `instr_*` / `data_*` ports and the memory.

## Interface
- MAX_OUTSTANDING, 2: granted-but-unanswered transactions allowed (1..4).
- STARVE_LIMIT, 4: consecutive contested data wins before the next contested grant is forced to instr (1..15).
- clk  in  1  clock, all state on rising edge.
- res  in  1  asynchronous, active-low reset.
- instr_req  in  1  fetch request; held with instr_adr until instr_gnt.
- instr_adr  in  32  fetch address.
- instr_gnt  out  1  fetch accepted this cycle.
- instr_r_valid  out  1  fetch read data valid.
- instr_read  out  32  fetch read data (= mem_read).
- data_req  in  1  data request; held with adr/we/wdata until data_gnt.
- data_adr  in  32  data address.
- data_write_enable  in  1  1 = store, 0 = load.
- data_write  in  32  store data.
- data_gnt  out  1  data request accepted this cycle.
- data_r_valid  out  1  data response valid (loads and stores both get one).
- data_read  out  32  load data (= mem_read).
- mem_req  out  1  request to memory.
- mem_adr  out  32  muxed address.
- mem_we  out  1  muxed write enable (0 for instr).
- mem_wdata  out  32  muxed write data (0 for instr).
- mem_gnt  in  1  memory accepted mem_req.
- mem_r_valid  in  1  memory response valid, in order.
- mem_read  in  32  memory read data.
- outstanding  out  3  current ID FIFO occupancy.
- resp_err  out  1  sticky: mem_r_valid arrived with empty FIFO.

## Operation
- FSM states ARB, HOLD. Register `owner` (0 = instr, 1 = data).
- ARB: if outstanding == MAX_OUTSTANDING, no request is presented (mem_req = 0). Otherwise winner chosen combinationally: only one requesting -> it; both requesting -> data, unless starve_cnt == STARVE_LIMIT -> instr. mem_req = 1, mem_adr/mem_we/mem_wdata from winner.
- ARB -> HOLD when mem_req=1 and mem_gnt=0; owner <= winner. ARB stays when granted or idle.
- HOLD: present owner's request unconditionally (OBI stability: never switch an un-granted request). HOLD -> ARB on mem_gnt. Requester dropping req in HOLD is a protocol violation; behaviour undefined.
- Grant: instr_gnt = mem_gnt & mem_req & (selected == instr); data_gnt likewise. Never both.
- On grant, push selected ID into FIFO. On mem_r_valid, pop head; head ID steers mem_r_valid to instr_r_valid or data_r_valid. Push and pop in the same cycle allowed, occupancy unchanged. Response may arrive the cycle after grant at earliest; same-cycle grant+response for the same transaction is not supported.
- mem_r_valid with empty FIFO: no r_valid output, no pop, resp_err <= 1 until reset.
- starve_cnt (4 bit): +1 on each data grant while instr_req=1; cleared on instr grant or any cycle instr_req=0; saturates at STARVE_LIMIT.
- instr_read and data_read are both wired to mem_read; consumers qualify with their r_valid.

## Timing
- Reset (res=0, asynchronous): state ARB, owner 0, FIFO empty, outstanding 0, starve_cnt 0, resp_err 0. All gnt/r_valid/mem_req outputs 0 while reset asserted, regardless of inputs.
- Arbitration and grant are zero-latency combinational (req -> mem_req, mem_gnt -> *_gnt in same cycle). Response routing is combinational from mem_r_valid and FIFO head.
- Back-to-back grants every cycle sustained while FIFO not full and mem_r_valid keeps pace.
- Full FIFO with concurrent mem_r_valid: mem_req stays 0 that cycle (occupancy checked from registered count), request presented next cycle.
- Reset mid-transaction discards all outstanding IDs; late mem_r_valid after reset sets resp_err.

## Test plan
- Single fetch: instr_req=1 adr 0x1C008000, mem_gnt=1 -> instr_gnt=1 same cycle, outstanding=1; mem_r_valid next cycle with 0x00000013 -> instr_r_valid=1, instr_read=0x00000013, outstanding=0.
- Contention: both req, STARVE_LIMIT=4, mem_gnt=1 always, instant responses -> data granted 4 cycles, 5th cycle instr_gnt=1, starve_cnt back to 0.
- Grant stall: data_req with mem_gnt=0 for 3 cycles, instr_req rises cycle 2 -> mem_adr stays data_adr, data_gnt on cycle mem_gnt=1, instr not granted before.
- Full: MAX_OUTSTANDING=2, two grants with no response -> mem_req=0, outstanding=2; first mem_r_valid routes to first requester, mem_req reasserted next cycle.
- Ordering: grant instr, data, instr; responses in order -> r_valid pulses instr, data, instr exactly.
- Error/reset: mem_r_valid with FIFO empty -> no r_valid, resp_err=1; res low mid-transaction -> outstanding=0, resp_err=0 immediately.
